// File: rtl/bus_arbiter_if.sv
// Purpose: request/grant bundle between the bus masters and the round-robin bus arbiter.
// Latency: none, wires only.
// Backpressure: a master holds its req_ low until it sees its grnt_ low, then releases req_ to end its tenure.
//
// Signals (all request/grant lines are active-low):
//   m0_req_..m3_req_     master -> arbiter  bus request
//   m0_grnt_..m3_grnt_   arbiter -> master  bus grant (at most one low)
//   bus_owner[1:0]       arbiter -> bus mux select, holds last owner when idle
//   bus_busy             arbiter -> high while any grant is asserted
//   timeout_irq          arbiter -> one-cycle pulse on forced revocation
// Modports: master = requester side, slave = arbiter side.
interface bus_arbiter_if;
    logic       m0_req_;
    logic       m1_req_;
    logic       m2_req_;
    logic       m3_req_;
    logic       m0_grnt_;
    logic       m1_grnt_;
    logic       m2_grnt_;
    logic       m3_grnt_;
    logic [1:0] bus_owner;
    logic       bus_busy;
    logic       timeout_irq;

    modport master (
        output m0_req_, m1_req_, m2_req_, m3_req_,
        input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
        input  bus_owner, bus_busy, timeout_irq
    );

    modport slave (
        input  m0_req_, m1_req_, m2_req_, m3_req_,
        output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
        output bus_owner, bus_busy, timeout_irq
    );
endinterface

// File: rtl/bus_arbiter.sv
// Purpose: four-master round-robin bus arbiter with registered, held grants and owner index.
// Latency: request sampled at edge N is granted after edge N; owner handover has zero dead cycles.
// Backpressure: no preemption; the owner keeps the bus until it releases req_ (or is revoked on timeout).
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-low reset
//   bus    bus_arbiter_if.slave: m*_req_ in, m*_grnt_ / bus_owner / bus_busy / timeout_irq out
// Optional feature: define ARB_TIMEOUT_EN to enable the ownership counter and forced revocation
// after TIMEOUT_CYCLES consecutive cycles when another master is waiting. Without it timeout_irq is 0.
module bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    // Configuration sanity: the ownership counter must be able to reach TIMEOUT_CYCLES-1.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || $clog2(TIMEOUT_CYCLES) > CNT_W) begin : g_bad_cfg
        $error("bus_arbiter: TIMEOUT_CYCLES out of range or does not fit in CNT_W");
    end

    // Explicit encoding so OWNk maps to k+1.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        OWN0 = 3'd1,
        OWN1 = 3'd2,
        OWN2 = 3'd3,
        OWN3 = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] last_owner_q, last_owner_d;
    logic [1:0] bus_owner_q, bus_owner_d;
    logic [3:0] grnt_n_q, grnt_n_d;
    logic       busy_q, busy_d;

    logic [3:0] req;        // active-high view of the requests
    logic [3:0] cand;       // requests eligible at this arbitration point
    logic [1:0] own_idx;
    logic       hold;       // current owner still requesting
    logic       revoke;     // forced release of a still-requesting owner
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;

    assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             irq_q;
    logic             new_grant;
`endif

    always_comb begin
        own_idx      = 2'd0;
        hold         = 1'b0;
        revoke       = 1'b0;
        cand         = req;
        found        = 1'b0;
        win          = 2'd0;
        idx          = 2'd0;
        state_d      = state_q;
        last_owner_d = last_owner_q;
        bus_owner_d  = bus_owner_q;
        grnt_n_d     = 4'hF;
        busy_d       = 1'b0;

        case (state_q)
            OWN0:    own_idx = 2'd0;
            OWN1:    own_idx = 2'd1;
            OWN2:    own_idx = 2'd2;
            OWN3:    own_idx = 2'd3;
            default: own_idx = 2'd0;
        endcase

        hold = (state_q != IDLE) && req[own_idx];

`ifdef ARB_TIMEOUT_EN
        // Revoke only when someone else is actually waiting; a lone owner keeps the bus.
        revoke = hold && (cnt_q == CNT_MAX) && ((req & ~(4'b0001 << own_idx)) != 4'b0000);
`endif
        // A revoked owner is excluded from the search it triggers.
        if (revoke) begin
            cand[own_idx] = 1'b0;
        end

        if (!hold || revoke) begin
            state_d = IDLE;
            // Cyclic search from last_owner+1; the 4th probe is last_owner itself.
            for (int i = 1; i <= 4; i++) begin
                idx = last_owner_q + 2'(i);
                if (!found && cand[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (found) begin
                state_d      = state_t'({1'b0, win} + 3'd1);
                last_owner_d = win;
                bus_owner_d  = win;
            end
        end

        // Grants are a one-hot decode of the next state, captured in flops so the
        // outputs never glitch while the state encoding changes.
        if (state_d != IDLE) begin
            grnt_n_d[state_d[1:0] - 2'd1] = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

`ifdef ARB_TIMEOUT_EN
    assign new_grant = (!hold || revoke) && found;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 2'd3;   // first search after reset starts at m0
            bus_owner_q  <= 2'd0;
            grnt_n_q     <= 4'hF;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            bus_owner_q  <= bus_owner_d;
            grnt_n_q     <= grnt_n_d;
            busy_q       <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Ownership counter: cleared per grant, counts held cycles, saturates at TIMEOUT_CYCLES-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            irq_q <= 1'b0;
        end else begin
            irq_q <= revoke;
            if (new_grant) begin
                cnt_q <= '0;
            end else if (hold && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.timeout_irq = irq_q;
`else
    assign bus.timeout_irq = 1'b0;
`endif

    assign bus.m0_grnt_  = grnt_n_q[0];
    assign bus.m1_grnt_  = grnt_n_q[1];
    assign bus.m2_grnt_  = grnt_n_q[2];
    assign bus.m3_grnt_  = grnt_n_q[3];
    assign bus.bus_owner = bus_owner_q;
    assign bus.bus_busy  = busy_q;

endmodule
